// File: rtl/prng_pkg.sv
// rtl/prng_pkg.sv - shared widths, sample types and the PRNG mixing function
package prng_pkg;

    localparam int STEP_W = 16;
    localparam int DATA_W = 8;

    typedef logic [STEP_W-1:0] step_t;

    typedef struct packed {
        logic [DATA_W-1:0] x;
        logic [DATA_W-1:0] y;
    } sample_t;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_e;

    // x = hi+lo, y = x+lo, all modulo 2^DATA_W
    function automatic sample_t prng_mix(step_t step);
        sample_t s;
        s.x = step[STEP_W-1:DATA_W] + step[DATA_W-1:0];
        s.y = s.x + step[DATA_W-1:0];
        return s;
    endfunction

endpackage

// File: rtl/prng_core.sv
// rtl/prng_core.sv - step counter with advance/load, combinational mix and wrap flag
module prng_core
    import prng_pkg::*;
#(
    parameter step_t SEED = 16'h0000
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    adv_i,
    input  logic    load_i,
    input  step_t   seed_i,
    output step_t   cnt_o,
    output sample_t sample_o,
    output logic    wrap_o
);

    step_t cnt_q, cnt_d;
    logic  wrap_q, wrap_d;

    // Load wins over advance; only an advance out of all-ones reports a wrap.
    always_comb begin
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        if (load_i) begin
            cnt_d = seed_i;
        end else if (adv_i) begin
            cnt_d  = cnt_q + 1'b1;
            wrap_d = (cnt_q == '1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= SEED;
            wrap_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
        end
    end

    assign cnt_o    = cnt_q;
    assign sample_o = prng_mix(cnt_q);
    assign wrap_o   = wrap_q;

endmodule

// File: rtl/prng_sched.sv
// rtl/prng_sched.sv - round-robin scheduler sharing one PRNG among NUM_REQ requesters
module prng_sched
    import prng_pkg::*;
#(
    parameter int    NUM_REQ = 4,
    parameter step_t SEED    = 16'h0000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    output logic [NUM_REQ-1:0]         gnt,
    input  logic                       cfg_load,
    input  logic [STEP_W-1:0]          cfg_seed,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_x,
    output logic [DATA_W-1:0]          out_y,
    output logic [STEP_W-1:0]          out_step,
    output logic [$clog2(NUM_REQ)-1:0] out_id,
    output logic                       wrap
);

    localparam int ID_W = $clog2(NUM_REQ);

    out_state_e      state_q, state_d;
    logic [ID_W-1:0] ptr_q, ptr_d;
    sample_t         smp_q, smp_d;
    step_t           step_q, step_d;
    logic [ID_W-1:0] id_q, id_d;

    logic            issue;
    logic            found;
    logic [ID_W-1:0] win_idx;
    step_t           cnt;
    sample_t         mix;

    prng_core #(
        .SEED (SEED)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .adv_i    (issue),
        .load_i   (cfg_load),
        .seed_i   (cfg_seed),
        .cnt_o    (cnt),
        .sample_o (mix),
        .wrap_o   (wrap)
    );

    // First requester at or after ptr, wrapping at NUM_REQ.
    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            int              j;
            logic [ID_W-1:0] k;
            j = int'(ptr_q) + i;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            k = ID_W'(j);
            if (!found && req[k]) begin
                found   = 1'b1;
                win_idx = k;
            end
        end
    end

    // rst gates the grant so nothing is offered while reset is held.
    assign issue = ~rst & found & ~cfg_load & ((state_q == EMPTY) | out_ready);

    always_comb begin
        gnt = '0;
        if (issue) begin
            gnt[win_idx] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        smp_d   = smp_q;
        step_d  = step_q;
        id_d    = id_q;
        if (issue) begin
            state_d = FULL;
            ptr_d   = (win_idx == ID_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
            smp_d   = mix;
            step_d  = cnt;
            id_d    = win_idx;
        end else if (state_q == FULL && out_ready) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            ptr_q   <= '0;
            smp_q   <= '0;
            step_q  <= '0;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            smp_q   <= smp_d;
            step_q  <= step_d;
            id_q    <= id_d;
        end
    end

    assign out_valid = (state_q == FULL);
    assign out_x     = smp_q.x;
    assign out_y     = smp_q.y;
    assign out_step  = step_q;
    assign out_id    = id_q;

endmodule

// File: tb/tb_prng_sched.sv
// tb/tb_prng_sched.sv - self-checking bench for prng_sched against a behavioural model
module tb_prng_sched;

    localparam int N = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req;
    logic [N-1:0]  gnt;
    logic          cfg_load;
    logic [15:0]   cfg_seed;
    logic          out_valid;
    logic          out_ready;
    logic [7:0]    out_x;
    logic [7:0]    out_y;
    logic [15:0]   out_step;
    logic [1:0]    out_id;
    logic          wrap;

    int checks   = 0;
    int failures = 0;

    int m_cnt, m_ptr, m_valid, m_x, m_y, m_step, m_id, m_wrap;

    prng_sched #(
        .NUM_REQ (N),
        .SEED    (16'h0000)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .cfg_load  (cfg_load),
        .cfg_seed  (cfg_seed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_x     (out_x),
        .out_y     (out_y),
        .out_step  (out_step),
        .out_id    (out_id),
        .wrap      (wrap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_ptr = 0; m_valid = 0;
        m_x = 0; m_y = 0; m_step = 0; m_id = 0; m_wrap = 0;
    endtask

    function automatic int exp_winner(input logic [N-1:0] r);
        for (int k = 0; k < N; k++) begin
            if (r[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic check_outputs();
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("out_x",     32'(out_x),     32'(m_x));
        chk("out_y",     32'(out_y),     32'(m_y));
        chk("out_step",  32'(out_step),  32'(m_step));
        chk("out_id",    32'(out_id),    32'(m_id));
        chk("wrap",      32'(wrap),      32'(m_wrap));
    endtask

    // One clock: check registered outputs, drive inputs, check grant, advance model.
    task automatic cyc(input logic [N-1:0] r, input logic l, input logic [15:0] s, input logic rdy);
        int           w;
        logic         iss;
        logic [N-1:0] eg;
        @(negedge clk);
        check_outputs();
        req = r; cfg_load = l; cfg_seed = s; out_ready = rdy;
        #1;
        w   = exp_winner(r);
        iss = (r != 0) && !l && (m_valid == 0 || rdy);
        eg  = iss ? (N'(1) << w) : '0;
        chk("gnt", 32'(gnt), 32'(eg));
        @(posedge clk);
        m_wrap = (iss && m_cnt == 65535) ? 1 : 0;
        if (l) m_cnt = int'(s);
        if (iss) begin
            m_x     = ((m_cnt >> 8) + (m_cnt % 256)) % 256;
            m_y     = (m_x + (m_cnt % 256)) % 256;
            m_step  = m_cnt;
            m_id    = w;
            m_cnt   = (m_cnt + 1) % 65536;
            m_ptr   = (w + 1) % N;
            m_valid = 1;
        end else if (m_valid == 1 && rdy) begin
            m_valid = 0;
        end
    endtask

    initial begin
        rst = 1'b1; req = 4'b0001; cfg_load = 1'b0; cfg_seed = '0; out_ready = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        chk("gnt_in_reset", 32'(gnt), 32'h0);
        check_outputs();
        req = '0;
        @(negedge clk);
        rst = 1'b0;

        // first samples from SEED
        cyc(4'b0001, 1'b0, 16'h0, 1'b1);
        #1;
        chk("tp1_x", 32'(out_x), 32'h0);
        chk("tp1_y", 32'(out_y), 32'h0);
        chk("tp1_step", 32'(out_step), 32'h0);
        chk("tp1_id", 32'(out_id), 32'h0);
        cyc(4'b0001, 1'b0, 16'h0, 1'b1);
        #1;
        chk("tp1b_x", 32'(out_x), 32'h1);
        chk("tp1b_y", 32'(out_y), 32'h2);
        chk("tp1b_step", 32'(out_step), 32'h1);

        // seed load, then load with requests pending
        cyc(4'b0000, 1'b1, 16'h0102, 1'b1);
        cyc(4'b0001, 1'b0, 16'h0, 1'b1);
        #1;
        chk("tp2_x", 32'(out_x), 32'h3);
        chk("tp2_y", 32'(out_y), 32'h5);
        chk("tp2_step", 32'(out_step), 32'h0102);
        cyc(4'b1111, 1'b1, 16'h0200, 1'b1);

        // wrap from all-ones
        cyc(4'b0000, 1'b1, 16'hFFFF, 1'b1);
        cyc(4'b0001, 1'b0, 16'h0, 1'b1);
        #1;
        chk("tp3_x", 32'(out_x), 32'hFE);
        chk("tp3_y", 32'(out_y), 32'hFD);
        chk("tp3_step", 32'(out_step), 32'hFFFF);
        chk("tp3_wrap", 32'(wrap), 32'h1);
        cyc(4'b0001, 1'b0, 16'h0, 1'b1);
        #1;
        chk("tp3b_step", 32'(out_step), 32'h0);
        chk("tp3b_wrap", 32'(wrap), 32'h0);

        // round robin with all requesting
        repeat (5) cyc(4'b1111, 1'b0, 16'h0, 1'b1);

        // back-pressure stall
        repeat (5) cyc(4'b1111, 1'b0, 16'h0, 1'b0);
        repeat (2) cyc(4'b1111, 1'b0, 16'h0, 1'b1);

        // async reset while holding a sample
        cyc(4'b1111, 1'b0, 16'h0, 1'b0);
        @(negedge clk);
        check_outputs();
        req = '0;
        rst = 1'b1;
        #1;
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_gnt", 32'(gnt), 32'h0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        cyc(4'b0010, 1'b0, 16'h0, 1'b1);
        #1;
        chk("tp6_step", 32'(out_step), 32'h0);
        chk("tp6_id", 32'(out_id), 32'h1);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [N-1:0] r;
            logic         l;
            logic [15:0]  s;
            logic         rdy;
            r   = N'($urandom);
            l   = ($urandom_range(0, 15) == 0);
            s   = ($urandom_range(0, 3) == 0) ? 16'(16'hFFFD + $urandom_range(0, 2)) : 16'($urandom);
            rdy = ($urandom_range(0, 9) < 7);
            cyc(r, l, s, rdy);
        end

        @(negedge clk);
        check_outputs();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/prng_sched.md
# prng_sched

Round-robin scheduler that shares the counter-driven PRNG datapath (16-bit step counter; x = hi+lo, y = hi+2·lo, mod 256) among `NUM_REQ` requesters. It advances the generator once per grant and returns each sample over a valid/ready output port, tagged with the winner's index. It also provides seed loading and a wrap indication. It sits between the PRNG core and the consumers that need random coordinates.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..16.
- `SEED`, default 16'h0000: step-counter value after reset.

- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `req`  in  NUM_REQ  level request per requester; held until its `gnt` bit is seen.
- `gnt`  out  NUM_REQ  one-hot grant, combinational, asserted only in an issue cycle.
- `cfg_load`  in  1  load `cfg_seed` into the step counter.
- `cfg_seed`  in  16  seed value.
- `out_valid`  out  1  sample available.
- `out_ready`  in  1  consumer accepts the sample.
- `out_x`, `out_y`  out  8 each  sample coordinates.
- `out_step`  out  16  counter value the sample was derived from.
- `out_id`  out  clog2(NUM_REQ)  index of the granted requester.
- `wrap`  out  1  one-cycle pulse when the counter rolls over from 16'hFFFF to 0.

## Operation
- States: `EMPTY` (`out_valid`=0) and `FULL` (`out_valid`=1).
- Issue condition: `issue = |req & ~cfg_load & (~out_valid | out_ready)`.
- Arbitration:
  - Pointer `ptr` starts at 0.
  - The winner is the first set `req` bit scanning from `ptr` upward, wrapping at `NUM_REQ`.
  - On issue, `ptr <= winner+1` (mod `NUM_REQ`). With no issue, `ptr` is unchanged.
- On issue, all in the same edge:
  - `gnt[winner]`=1.
  - `out_x <= hi+lo` and `out_y <= (hi+lo)+lo`, both truncated to 8 bits, where hi/lo are the current counter bytes.
  - `out_step <= cnt`, `out_id <= winner`, `cnt <= cnt+1`, state `FULL`.
- `FULL` with `out_ready`=1 and no issue: go to `EMPTY`. Output registers hold their last values.
- `FULL` with `out_ready`=0: `out_x`, `out_y`, `out_step`, `out_id` stay stable. No grant; `cnt` frozen.
- Back-to-back operation: accept and issue in the same cycle keeps the state `FULL` with new data, giving one sample per cycle.
- `cfg_load`:
  - `cnt <= cfg_seed`.
  - Blocks issue that cycle and has priority over requests.
  - Does not disturb a held output sample or `ptr`.
- `wrap`: asserted in the cycle after an issue at `cnt`=16'hFFFF; the counter becomes 0. A `cfg_load` never raises `wrap`.
- Requesters deasserting `req` without a grant is legal; there is no penalty and `ptr` is unchanged.

## Timing
- Reset values:
  - `cnt`=`SEED`, `ptr`=0, `out_valid`=0.
  - `out_x`, `out_y`, `out_step`, `out_id` = 0.
  - `wrap`=0.
  - `gnt`=0 while `rst` is high.
- Latency: `gnt` in cycle N, `out_valid` and data in cycle N+1.
- Reset mid-operation discards any held sample immediately (async). The first grant after deassertion uses `cnt`=`SEED`.
- `gnt` depends combinationally on `req`, `cfg_load`, `out_ready` and state. No combinational path exists from `req` to `out_*`.

## Structure
- Package `prng_pkg`:
  - `STEP_W`=16, `DATA_W`=8.
  - Typedef `step_t` and `sample_t` (x, y).
  - Function `prng_mix(step_t)` returning `sample_t`.
- Sub-module `prng_core`:
  - Contents: step counter with `adv`/`load` inputs, combinational `prng_mix`, and the `wrap` flag.
  - The scheduler owns arbitration, the handshake and the output registers.

## Test plan
- Reset, `SEED`=0, `req`=0001, `out_ready`=1 → `gnt`=0001. Next cycle: x=0, y=0, step=0, id=0. Following sample: x=1, y=2, step=1.
- `cfg_load` with seed 16'h0102, then one grant → x=3, y=5, step=16'h0102. Same cycle as `cfg_load` with `req` high → `gnt`=0.
- Seed 16'hFFFF, one grant → x=8'hFE, y=8'hFD, step=16'hFFFF, `wrap` pulse. Next sample: step=0, x=0, y=0.
- `req`=1111 held, `out_ready`=1 → `gnt` sequence 0001, 0010, 0100, 1000, 0001 on consecutive cycles, with `out_step` incrementing by 1 per cycle.
- `out_ready`=0 for 5 cycles while `FULL` → outputs stable, `gnt`=0, `cnt` unchanged. On `out_ready`=1 the next grant goes to the round-robin successor.
- `rst` pulse while `FULL` with `out_ready`=0 → `out_valid`=0 immediately, `ptr`=0, next sample step=`SEED`.
